start_srl_fifo: RTL and testbench



---
 rtl/start_fifo_pkg.sv | 19 +
 rtl/start_srl_fifo_storage.sv | 45 ++++
 rtl/start_srl_fifo.sv | 115 +++++++++++
 tb/tb_start_srl_fifo.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/start_fifo_pkg.sv
// Shared definitions for HLS start-token FIFOs.
//   cnt_width()      : width of an occupancy counter able to hold 0..depth
//   DefaultDepth     : default start FIFO capacity
//   DefaultDataWidth : default token width
//   DefaultAddrWidth : default read-address width (covers DefaultDepth)
//   RstActive        : asserted level of the asynchronous reset
package start_fifo_pkg;

  localparam int unsigned DefaultDepth     = 2;
  localparam int unsigned DefaultDataWidth = 1;
  localparam int unsigned DefaultAddrWidth = 1;
  localparam logic        RstActive        = 1'b1;

  // Counter must represent every value in 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/start_srl_fifo_storage.sv
// Shift-register (SRL) storage array for start_srl_fifo.
//   clk  : clock
//   we   : shift enable; entry 0 takes din, every other entry moves up by one
//   addr : read address (0 = newest entry)
//   din  : write data
//   dout : mem[addr], combinational
// No reset: contents are only ever exposed while the controller reports data valid.
module start_srl_fifo_storage #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned ADDR_WIDTH = 1,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_d[i] = mem_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Address space may be larger than DEPTH; out-of-range reads return zero.
  always_comb begin
    dout = '0;
    if (32'(addr) < DEPTH) begin
      dout = mem_q[addr];
    end
  end

endmodule

// File: rtl/start_srl_fifo.sv
// Start-token FIFO between an HLS dataflow producer and a PE consumer.
// Controller owns occupancy count, read address and registered full/empty flags;
// data lives in start_srl_fifo_storage.
//   clk, reset               : clock, asynchronous active-high reset
//   if_write_ce, if_write    : push enable / request
//   if_din                   : push data
//   if_full_n                : 1 = space available
//   if_read_ce, if_read      : pop enable / request
//   if_dout                  : head-of-queue data (valid only while if_empty_n)
//   if_empty_n               : 1 = data valid
// Optional (define START_SRL_FIFO_OCC_EN):
//   if_num_data_valid        : current occupancy (registered)
//   if_fifo_cap              : constant capacity
module start_srl_fifo
  import start_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
  parameter int unsigned DEPTH      = DefaultDepth
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                if_write_ce,
  input  logic                                if_write,
  input  logic [DATA_WIDTH-1:0]               if_din,
  output logic                                if_full_n,
  input  logic                                if_read_ce,
  input  logic                                if_read,
  output logic [DATA_WIDTH-1:0]               if_dout,
`ifdef START_SRL_FIFO_OCC_EN
  output logic [cnt_width(DEPTH)-1:0]         if_num_data_valid,
  output logic [cnt_width(DEPTH)-1:0]         if_fifo_cap,
`endif
  output logic                                if_empty_n
);

  localparam int unsigned CntW = cnt_width(DEPTH);

  logic [CntW-1:0]       count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  empty_n_q, empty_n_d;
  logic                  full_n_q, full_n_d;
  logic                  push, pop;

  assign push = if_write & if_write_ce & full_n_q;
  assign pop  = if_read & if_read_ce & empty_n_q;

  always_comb begin
    count_d   = count_q;
    empty_n_d = empty_n_q;
    full_n_d  = full_n_q;
    case ({push, pop})
      2'b10: begin
        count_d   = count_q + CntW'(1);
        empty_n_d = 1'b1;
        if (count_q == CntW'(DEPTH - 1)) begin
          full_n_d = 1'b0;
        end
      end
      2'b01: begin
        count_d  = count_q - CntW'(1);
        full_n_d = 1'b1;
        if (count_q == CntW'(1)) begin
          empty_n_d = 1'b0;
        end
      end
      // Push and pop together: the shift moves the next-oldest entry under the
      // unchanged address, so nothing in the controller needs to change.
      default: ;
    endcase
  end

  // Address is registered so dout comes straight from the storage mux.
  always_comb begin
    addr_d = '0;
    if (count_d != '0) begin
      addr_d = ADDR_WIDTH'(count_d - CntW'(1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset == RstActive) begin
      count_q   <= '0;
      addr_q    <= '0;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
    end else begin
      count_q   <= count_d;
      addr_q    <= addr_d;
      empty_n_q <= empty_n_d;
      full_n_q  <= full_n_d;
    end
  end

  start_srl_fifo_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_storage (
    .clk  (clk),
    .we   (push),
    .addr (addr_q),
    .din  (if_din),
    .dout (if_dout)
  );

  assign if_empty_n = empty_n_q;
  assign if_full_n  = full_n_q;

`ifdef START_SRL_FIFO_OCC_EN
  assign if_num_data_valid = count_q;
  assign if_fifo_cap       = CntW'(DEPTH);
`endif

endmodule

// File: tb/tb_start_srl_fifo.sv
module tb_start_srl_fifo;

  localparam int unsigned Depth = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wce = 1'b1, wr = 1'b0, rce = 1'b1, rd = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       full_n, empty_n;

  int errors = 0;
  int checks = 0;

  // Reference queue: contents in arrival order, head at index 0.
  logic [7:0] mq[$];

  always #5 clk = ~clk;

`ifdef START_SRL_FIFO_OCC_EN
  logic [1:0] num2, cap2;
  logic       o_wr = 1'b0, o_rd = 1'b0;
  logic [7:0] o_din = '0, o_dout;
  logic       o_full_n, o_empty_n;
  logic [2:0] o_num, o_cap;
`endif

  start_srl_fifo #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (1),
    .DEPTH      (Depth)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .if_write_ce       (wce),
    .if_write          (wr),
    .if_din            (din),
    .if_full_n         (full_n),
    .if_read_ce        (rce),
    .if_read           (rd),
    .if_dout           (dout),
`ifdef START_SRL_FIFO_OCC_EN
    .if_num_data_valid (num2),
    .if_fifo_cap       (cap2),
`endif
    .if_empty_n        (empty_n)
  );

`ifdef START_SRL_FIFO_OCC_EN
  start_srl_fifo #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (2),
    .DEPTH      (4)
  ) dut_occ (
    .clk               (clk),
    .reset             (reset),
    .if_write_ce       (1'b1),
    .if_write          (o_wr),
    .if_din            (o_din),
    .if_full_n         (o_full_n),
    .if_read_ce        (1'b1),
    .if_read           (o_rd),
    .if_dout           (o_dout),
    .if_num_data_valid (o_num),
    .if_fifo_cap       (o_cap),
    .if_empty_n        (o_empty_n)
  );
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a push needs room, a pop needs data, both judged on state before the edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
    end else if (rd && rce && mq.size() > 0 && wr && wce && mq.size() < Depth) begin
      void'(mq.pop_front());
      mq.push_back(din);
    end else if (rd && rce && mq.size() > 0) begin
      void'(mq.pop_front());
    end else if (wr && wce && mq.size() < Depth) begin
      mq.push_back(din);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("empty_n", 32'(empty_n), 32'(mq.size() > 0));
    chk("full_n", 32'(full_n), 32'(mq.size() < Depth));
    if (mq.size() > 0) chk("dout", 32'(dout), 32'(mq[0]));
`ifdef START_SRL_FIFO_OCC_EN
    chk("num_data_valid", 32'(num2), 32'(mq.size()));
    chk("fifo_cap", 32'(cap2), 32'd2);
`endif
  end

  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    wr  = w;
    din = d;
    rd  = r;
    @(posedge clk);
    #1;
    wr = 1'b0;
    rd = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_empty_n", 32'(empty_n), 32'd0);
    chk("reset_full_n", 32'(full_n), 32'd1);

    // Fill / drain
    cyc(1'b1, 8'hA1, 1'b0);
    chk("push1_empty_n", 32'(empty_n), 32'd1);
    chk("push1_dout", 32'(dout), 32'hA1);
    chk("push1_full_n", 32'(full_n), 32'd1);
    cyc(1'b1, 8'hB2, 1'b0);
    chk("push2_full_n", 32'(full_n), 32'd0);
    cyc(1'b1, 8'hC3, 1'b0);
    chk("push3_ignored_dout", 32'(dout), 32'hA1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("pop1_dout", 32'(dout), 32'hB2);
    chk("pop1_full_n", 32'(full_n), 32'd1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("pop2_empty_n", 32'(empty_n), 32'd0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("pop_empty_ignored", 32'(full_n), 32'd1);

    // Simultaneous push + pop at count=1
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b1);
    chk("pushpop_dout", 32'(dout), 32'h22);
    chk("pushpop_empty_n", 32'(empty_n), 32'd1);
    chk("pushpop_full_n", 32'(full_n), 32'd1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("pushpop_drain", 32'(empty_n), 32'd0);

    // Full + pop + push: only the pop lands
    cyc(1'b1, 8'h01, 1'b0);
    cyc(1'b1, 8'h02, 1'b0);
    cyc(1'b1, 8'h03, 1'b1);
    chk("fullpp_full_n", 32'(full_n), 32'd1);
    chk("fullpp_dout", 32'(dout), 32'h02);
    cyc(1'b1, 8'h03, 1'b0);
    chk("reissue_full_n", 32'(full_n), 32'd0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("reissue_dout", 32'(dout), 32'h03);
    cyc(1'b0, 8'h00, 1'b1);

    // Clock enables
    wce = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'h77, 1'b0);
    chk("wce_block_empty_n", 32'(empty_n), 32'd0);
    wce = 1'b1;
    cyc(1'b1, 8'h44, 1'b0);
    rce = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("rce_block_empty_n", 32'(empty_n), 32'd1);
    chk("rce_block_dout", 32'(dout), 32'h44);
    rce = 1'b1;
    wce = 1'b0;
    cyc(1'b1, 8'h99, 1'b1);
    chk("wce_off_pop_on", 32'(empty_n), 32'd0);
    wce = 1'b1;

    // Asynchronous reset with one entry held
    cyc(1'b1, 8'h55, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_empty_n", 32'(empty_n), 32'd0);
    chk("async_rst_full_n", 32'(full_n), 32'd1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) cyc(1'b0, 8'h00, 1'b0);
    chk("post_rst_idle", 32'(empty_n), 32'd0);
    cyc(1'b1, 8'h66, 1'b0);
    chk("post_rst_dout", 32'(dout), 32'h66);
    cyc(1'b0, 8'h00, 1'b1);

`ifdef START_SRL_FIFO_OCC_EN
    for (int i = 0; i < 3; i++) begin
      o_wr  = 1'b1;
      o_din = 8'(8'h30 + i);
      @(posedge clk);
      #1 o_wr = 1'b0;
    end
    chk("occ_num3", 32'(o_num), 32'd3);
    chk("occ_cap", 32'(o_cap), 32'd4);
    chk("occ_dout", 32'(o_dout), 32'h30);
    o_rd = 1'b1;
    @(posedge clk);
    #1 o_rd = 1'b0;
    chk("occ_num2", 32'(o_num), 32'd2);
    chk("occ_dout2", 32'(o_dout), 32'h31);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
